// File: rtl/pwm_multi_peripheral.sv
// Multi-channel PWM sharing one prescaled counter, with edge/centre alignment
// and double-buffered duty, period and mode that change only at period boundaries.
module pwm_multi_peripheral #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         en_out,
  input  logic [NUM_CH-1:0]         en_pwm,
  input  logic [NUM_CH*CNT_W-1:0]   duty,
  input  logic [CNT_W-1:0]          period,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic                      center,
  input  logic                      update,
  output logic [NUM_CH-1:0]         out,
  output logic                      period_start,
  output logic [CNT_W-1:0]          cnt_out
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [PRESC_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]   period_sh_q;
  logic               center_sh_q;
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               period_start_q;

  logic [CNT_W-1:0]   peff;
  logic               tick;
  logic               boundary;
  logic               load;

  // Centre mode treats a zero period as one so the up/down walk stays well formed.
  assign peff = (period_sh_q == '0) ? CNT_W'(1) : period_sh_q;
  // >= lets the prescaler recover at once if prescale is lowered below pre_q.
  assign tick = run && (pre_q >= prescale);
  assign boundary = tick && (center_sh_q ? ((dir_q == DIR_DOWN) && (cnt_q == '0))
                                         : (cnt_q == period_sh_q));
  // While stopped the shadows are transparent to any pending or fresh update.
  assign load = (pending_q || update) && (boundary || !run);
  assign pending_d = load ? 1'b0 : (pending_q || update);

  always_comb begin
    pre_d = pre_q + PRESC_W'(1);
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!run) begin
      pre_d = '0;
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      pre_d = '0;
      if (boundary) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (!center_sh_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == peff - CNT_W'(1)) dir_d = DIR_DOWN;
        else                           cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q == '0) dir_d = DIR_UP;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en_out[i])      out_d[i] = 1'b0;
      else if (!en_pwm[i]) out_d[i] = 1'b1;
      else                 out_d[i] = run && (cnt_q < duty_sh_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      pending_q      <= 1'b0;
      period_sh_q    <= '1;
      center_sh_q    <= 1'b0;
      out_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) duty_sh_q[i] <= '0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      pending_q      <= pending_d;
      out_q          <= out_d;
      period_start_q <= boundary;
      if (load) begin
        period_sh_q <= period;
        center_sh_q <= center;
        for (int i = 0; i < NUM_CH; i++) duty_sh_q[i] <= duty[i*CNT_W +: CNT_W];
      end
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;
  assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_pwm_multi_peripheral.sv
// Bench for pwm_multi_peripheral: directed scenarios plus random traffic, all
// checked every cycle against a phase-index model of the PWM period.
module tb_pwm_multi_peripheral;
  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int W       = 1 + CNT_W + NUM_CH;

  logic                    clk;
  logic                    rst_n;
  logic                    run;
  logic [NUM_CH-1:0]       en_out;
  logic [NUM_CH-1:0]       en_pwm;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [CNT_W-1:0]        period;
  logic [PRESC_W-1:0]      prescale;
  logic                    center;
  logic                    update;
  logic [NUM_CH-1:0]       out;
  logic                    period_start;
  logic [CNT_W-1:0]        cnt_out;

  pwm_multi_peripheral #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .en_out(en_out), .en_pwm(en_pwm),
    .duty(duty), .period(period), .prescale(prescale), .center(center),
    .update(update), .out(out), .period_start(period_start), .cnt_out(cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: position within the period is a phase index k in 0..len-1;
  // the counter value is derived from k arithmetically.
  int          m_pre, m_k, m_psh;
  bit          m_csh, m_pend, m_ps;
  int          m_dsh [NUM_CH];
  logic [NUM_CH-1:0] m_out;

  function automatic int peff_f();
    return (m_psh == 0) ? 1 : m_psh;
  endfunction

  function automatic int len_f();
    return m_csh ? 2 * peff_f() : m_psh + 1;
  endfunction

  function automatic int cnt_f();
    if (!m_csh) return m_k;
    return (m_k < peff_f()) ? m_k : 2 * peff_f() - 1 - m_k;
  endfunction

  task automatic model_step();
    int c;
    bit tick, bnd, ld;
    if (!rst_n) begin
      m_pre = 0; m_k = 0; m_psh = 255; m_csh = 0; m_pend = 0; m_ps = 0; m_out = '0;
      for (int i = 0; i < NUM_CH; i++) m_dsh[i] = 0;
    end else begin
      c    = cnt_f();
      tick = run && (m_pre >= int'(prescale));
      bnd  = tick && (m_k == len_f() - 1);
      for (int i = 0; i < NUM_CH; i++)
        m_out[i] = en_out[i] ? (en_pwm[i] ? (run && (c < m_dsh[i])) : 1'b1) : 1'b0;
      m_ps = bnd;
      ld   = (m_pend || update) && (bnd || !run);
      if (!run) begin
        m_pre = 0; m_k = 0;
      end else if (tick) begin
        m_pre = 0;
        m_k   = bnd ? 0 : m_k + 1;
      end else begin
        m_pre++;
      end
      if (ld) begin
        m_psh = int'(period);
        m_csh = center;
        for (int i = 0; i < NUM_CH; i++) m_dsh[i] = int'(duty[i*CNT_W +: CNT_W]);
      end
      m_pend = ld ? 1'b0 : (m_pend || update);
    end
  endtask

  task automatic cycle();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    model_step();
    exp_q.push_back({m_ps, CNT_W'(cnt_f()), m_out});
    e = exp_q.pop_front();
    check_eq("period_start", 32'(period_start), 32'(e[W-1]));
    check_eq("cnt_out", 32'(cnt_out), 32'(e[W-2 -: CNT_W]));
    check_eq("out", 32'(out), 32'(e[NUM_CH-1:0]));
  endtask

  task automatic window(input int n, output int ps_n, output int h0, output int h1, output int h2);
    ps_n = 0; h0 = 0; h1 = 0; h2 = 0;
    for (int j = 0; j < n; j++) begin
      cycle();
      ps_n += int'(period_start);
      h0   += int'(out[0]);
      h1   += int'(out[1]);
      h2   += int'(out[2]);
    end
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (int'(cnt_out) != v && n < 600) begin
      cycle();
      n++;
    end
    check_eq("wait_cnt", 32'(cnt_out), 32'(v));
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (!period_start && n < 600) begin
      cycle();
      n++;
    end
    check_eq("wait_ps", 32'(period_start), 32'd1);
  endtask

  // Load new settings by stopping for one cycle with an update strobe.
  task automatic load_stopped();
    run = 1'b0; update = 1'b1;
    cycle();
    update = 1'b0; run = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    int n, ps_n, h0, h1, h2;
    rst_n = 1'b0; run = 1'b1; en_out = '1; en_pwm = '1; duty = '0;
    period = 8'd9; prescale = '0; center = 1'b0; update = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int j = 0; j < 50; j++) cycle();

    // Reset mid-period
    rst_n = 1'b0;
    cycle();
    cycle();
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_cnt", 32'(cnt_out), 32'd0);
    check_eq("rst_ps", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!period_start && n < 400);
    check_eq("first_ps_delay", 32'(n), 32'd256);

    // Edge mode, period 10
    period = 8'd9;
    duty[0*CNT_W +: CNT_W] = 8'd3;
    duty[1*CNT_W +: CNT_W] = 8'd0;
    duty[2*CNT_W +: CNT_W] = 8'd10;
    load_stopped();
    window(30, ps_n, h0, h1, h2);
    check_eq("edge_ps", 32'(ps_n), 32'd3);
    check_eq("edge_ch0", 32'(h0), 32'd9);
    check_eq("edge_ch1", 32'(h1), 32'd0);
    check_eq("edge_ch2", 32'(h2), 32'd30);

    // Static high and disabled channels
    en_pwm[5] = 1'b0;
    en_out[6] = 1'b0;
    duty[6*CNT_W +: CNT_W] = 8'd5;
    run = 1'b0;
    cycle();
    check_eq("static_stop_ch5", 32'(out[5]), 32'd1);
    check_eq("static_stop_ch6", 32'(out[6]), 32'd0);
    run = 1'b1;
    cycle();
    cycle();
    check_eq("static_run_ch5", 32'(out[5]), 32'd1);
    check_eq("static_run_ch6", 32'(out[6]), 32'd0);

    // Prescaler: 4 clocks per tick, 5 ticks per period
    prescale = 8'd3; period = 8'd4;
    duty[0*CNT_W +: CNT_W] = 8'd2;
    load_stopped();
    window(40, ps_n, h0, h1, h2);
    check_eq("presc_ps", 32'(ps_n), 32'd2);
    check_eq("presc_ch0", 32'(h0), 32'd16);

    // Centre mode
    prescale = '0; center = 1'b1; period = 8'd4;
    duty[0*CNT_W +: CNT_W] = 8'd1;
    load_stopped();
    window(16, ps_n, h0, h1, h2);
    check_eq("ctr_ps", 32'(ps_n), 32'd2);
    check_eq("ctr_ch0", 32'(h0), 32'd4);
    period = 8'd0;
    load_stopped();
    window(8, ps_n, h0, h1, h2);
    check_eq("ctr_p0_ps", 32'(ps_n), 32'd4);
    check_eq("ctr_p0_ch0", 32'(h0), 32'd8);

    // Double buffering: mid-period update waits for the boundary
    center = 1'b0; period = 8'd9;
    duty[0*CNT_W +: CNT_W] = 8'd3;
    load_stopped();
    wait_cnt(4);
    duty[0*CNT_W +: CNT_W] = 8'd7;
    update = 1'b1;
    cycle();
    update = 1'b0;
    wait_ps();
    window(10, ps_n, h0, h1, h2);
    check_eq("dbuf_ch0", 32'(h0), 32'd7);

    // Update in the boundary cycle applies to the very next period
    wait_cnt(9);
    duty[0*CNT_W +: CNT_W] = 8'd2;
    update = 1'b1;
    cycle();
    update = 1'b0;
    check_eq("bnd_ps", 32'(period_start), 32'd1);
    window(10, ps_n, h0, h1, h2);
    check_eq("bnd_ch0", 32'(h0), 32'd2);

    // Edge to centre switch only takes effect at the boundary
    wait_cnt(3);
    center = 1'b1; period = 8'd4;
    update = 1'b1;
    cycle();
    update = 1'b0;
    wait_ps();
    window(8, ps_n, h0, h1, h2);
    check_eq("mode_ps", 32'(ps_n), 32'd1);
    check_eq("mode_ch0", 32'(h0), 32'd4);

    // Random traffic
    en_out = '1; en_pwm = '1;
    for (int c = 0; c < 2500; c++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      run    = ($urandom_range(0, 15) != 0);
      update = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0)  period   = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 31) == 0) prescale = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) center   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
      end
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 3) == 0) duty[ch*CNT_W +: CNT_W] = 8'($urandom_range(0, 14));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_peripheral.md
Name: pwm_multi_peripheral

Overview:
Parametrised successor to the onboarding PWM peripheral. It provides NUM_CH independent PWM channels sharing one prescaled counter. Each channel has its own duty cycle, and the block adds a programmable period, edge- or centre-aligned modes, and double-buffered (glitch-free) updates of duty, period and mode. It sits between the SPI register file and the output pins; out[] drives {uio_out, uo_out} in the default configuration.

Parameters:
NUM_CH, 16, number of PWM output channels
CNT_W, 8, width of counter, period and per-channel duty
PRESC_W, 8, width of prescaler divide value

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
run  in  1  global counter enable
en_out  in  NUM_CH  per-channel output enable
en_pwm  in  NUM_CH  per-channel PWM enable (0 = static high when en_out=1)
duty  in  NUM_CH*CNT_W  channel i duty at bits [i*CNT_W +: CNT_W]
period  in  CNT_W  period setting P
prescale  in  PRESC_W  tick every prescale+1 clocks
center  in  1  0 = edge-aligned, 1 = centre-aligned
update  in  1  one-cycle strobe: arm transfer of duty/period/center to shadow registers
out  out  NUM_CH  registered channel outputs
period_start  out  1  one-cycle pulse on every period boundary tick
cnt_out  out  CNT_W  current counter value

Behaviour:
- Reset (rst_n=0 at a clk edge): out=0, period_start=0, cnt=0, dir=up, prescaler=0, pending=0. Shadow registers reset to duty_sh=0, period_sh=all-ones, center_sh=0. Reset mid-period aborts the period immediately.
- Prescaler: pre counts 0..prescale. tick=1 in the cycle where pre==prescale, and pre then wraps to 0. prescale=0 gives tick every cycle. The live prescale input is used (not shadowed).
- Edge mode (center_sh=0): on each tick, cnt increments 0..period_sh, then wraps to 0. Period length = (period_sh+1) ticks. Boundary = tick with cnt==period_sh.
- Centre mode (center_sh=1): Peff = max(period_sh,1).
  - Up phase: on tick, if cnt==Peff-1 then dir<=down (cnt holds), else cnt++.
  - Down phase: on tick, if cnt==0 then dir<=up (cnt holds), else cnt--.
  - Period = 2*Peff ticks. Boundary = tick with dir==down and cnt==0.
- At every boundary, the next counter value is 0 with dir=up, in both modes. period_start is registered: it is high the cycle after the boundary tick.
- run=0: pre, cnt and dir are held at 0/up, period_start=0, and all PWM-enabled channels output 0. Any pending update loads on the next cycle (shadows transparent while stopped). When run returns to 1, counting starts at cnt=0.
- Double buffering:
  - update sets pending.
  - At a boundary tick with pending=1 (or pending/update in the same cycle as the boundary), duty_sh, period_sh and center_sh load from the inputs, and pending clears.
  - update asserted in the boundary cycle itself loads in that cycle.
  - Repeated update strobes before a boundary collapse into one load, using input values sampled at the load cycle.
- Channel i output, registered with one-cycle latency, computed from the current cycle's cnt, duty_sh and enables:
  - en_out[i]=0 → 0
  - en_out[i]=1, en_pwm[i]=0 → 1
  - otherwise → run && (cnt < duty_sh[i]), unsigned compare
- Width/boundary rules:
  - duty=0 → constant 0.
  - Edge mode: duty ≥ period_sh+1 → constant 1; high time = min(duty, P+1) ticks.
  - Centre mode: high time = 2*min(duty, Peff) ticks, symmetric about the boundary.
  - Counter never exceeds period_sh. A period_sh change loads only at a boundary, so no overrun.
- cnt_out = cnt register (no extra latency).

Test Plan:
- Reset: run a period, assert rst_n=0 for 2 cycles mid-period → out=0, cnt_out=0, period_start=0; first period_start occurs exactly period_sh+1 ticks after release (default 256 with prescale 0).
- Edge: prescale=0, period=9, duty ch0=3, ch1=0, ch2=10, all en=1, update pulse, run=1 → ch0 high 3 of every 10 clocks, ch1 always 0, ch2 always 1, period_start every 10 clocks.
- Static/enable: en_out[5]=1, en_pwm[5]=0 → out[5]=1 constantly, including when run=0. en_out[6]=0, en_pwm[6]=1, duty=5 → out[6]=0.
- Prescaler: prescale=3, period=4, duty ch0=2 → period 20 clocks, ch0 high 8 consecutive clocks, cnt_out steps every 4 clocks.
- Centre: center=1, period=4, duty ch0=1, prescale=0 → period 8 clocks. ch0 high 2 consecutive clocks (down-0 then up-0) straddling each period_start. period=0 behaves as period=1 (period 2 clocks).
- Double buffer: duty ch0 3→7 with update strobed mid-period → current period keeps 3, next period uses 7. update strobed in the exact boundary cycle → new values apply to the immediately following period. Mode switch edge→centre applied only at the boundary.
